// File: rtl/apb_cmd_master.sv
// APB4 initiator: converts a valid/ready command stream into single APB transfers.
// Optional watchdog on PREADY enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int PADDR_SIZE     = 6,
    parameter int PDATA_SIZE     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [2:0]              PPROT,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic cmd_fire;
    logic access_ok;
    logic timeout_hit;

    assign cmd_fire  = cmd_valid && (state == IDLE);
    assign access_ok = (state == ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Fires on the last permitted stalled cycle; a PREADY in that cycle completes normally.
    assign timeout_hit = (state == ACCESS) && !PREADY &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_timeout <= 1'b0;
        end else if (access_ok) begin
            rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
            rsp_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    // TIMEOUT_CYCLES has no effect without the watchdog.
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
    assign rsp_timeout        = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // APB request fields only change when a new command is taken.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PSTRB  <= '0;
            PPROT  <= 3'b000;
        end else if (cmd_fire) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
            PSTRB  <= cmd_write ? cmd_strb : '0;
            PPROT  <= cmd_prot;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (access_ok) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
        end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);

endmodule
